// File: rtl/axi_stream_capture.sv
// rtl/axi_stream_capture.sv - stream frame capture into a word buffer with a packet descriptor FIFO
module axi_stream_capture #(
   parameter  int DATA_W    = 32,
   parameter  int DEPTH     = 1024,
   parameter  int PKT_DEPTH = 16,
   localparam int LEN_W     = $clog2(DEPTH) + 1
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                S_TVALID,
   input  logic [DATA_W-1:0]   S_TDATA,
   input  logic [DATA_W/8-1:0] S_TKEEP,
   input  logic                S_TLAST,
   output logic                S_TREADY,
   input  logic                RD_EN,
   output logic [DATA_W-1:0]   RD_DATA,
   output logic                RD_VALID,
   output logic                RD_LAST,
   output logic                PKT_AVAIL,
   output logic [LEN_W-1:0]    PKT_LEN,
   output logic [31:0]         PKT_NUM,
   output logic [15:0]         DROP_CNT,
   output logic                OVERFLOW
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PIW = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
   localparam int CW  = $clog2(PKT_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RECV, DROP} wstate_t;

   wstate_t           state, st_n;
   logic [LEN_W-1:0]  wr_spec, wr_commit, rd_ptr, frame_len, rd_word;
   logic [LEN_W-1:0]  spec_n, commit_n, flen_n, len_t, spec_t, stored_inc;
   logic [PIW-1:0]    desc_head, desc_tail;
   logic [CW-1:0]     desc_cnt;
   logic              beat, stored, buf_full, desc_full;
   logic              mem_we, push, drop, rd_fire, pop;
   logic [LEN_W-1:0]  head_len;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [LEN_W-1:0]  desc_mem [PKT_DEPTH];

   function automatic logic [PIW-1:0] idx_next(input logic [PIW-1:0] i);
      return (i == PIW'(PKT_DEPTH - 1)) ? '0 : i + PIW'(1);
   endfunction

   assign S_TREADY   = ~ARESET;
   assign beat       = S_TVALID & S_TREADY;
   assign stored     = |S_TKEEP;
   assign stored_inc = {{(LEN_W-1){1'b0}}, stored};
   assign len_t      = frame_len + stored_inc;
   assign spec_t     = wr_spec + stored_inc;
   assign buf_full   = (wr_spec - rd_ptr) == LEN_W'(DEPTH);
   assign desc_full  = desc_cnt == CW'(PKT_DEPTH);
   assign head_len   = desc_mem[desc_head];
   assign PKT_AVAIL  = desc_cnt != '0;
   assign PKT_LEN    = PKT_AVAIL ? head_len : '0;
   assign rd_fire    = RD_EN & PKT_AVAIL;
   assign pop        = rd_fire & ((rd_word + LEN_W'(1)) == head_len);

   // Words land at wr_spec; only a commit moves wr_commit, so a dropped frame rewinds cleanly.
   always_comb begin
      st_n     = state;
      spec_n   = wr_spec;
      commit_n = wr_commit;
      flen_n   = frame_len;
      mem_we   = 1'b0;
      push     = 1'b0;
      drop     = 1'b0;
      if (beat) begin
         if (state == DROP) begin
            if (S_TLAST) st_n = IDLE;
         end else if (stored && buf_full) begin
            drop   = 1'b1;
            spec_n = wr_commit;
            flen_n = '0;
            st_n   = S_TLAST ? IDLE : DROP;
         end else begin
            mem_we = stored;
            if (S_TLAST) begin
               flen_n = '0;
               st_n   = IDLE;
               if (len_t == '0) begin
                  spec_n = wr_commit;
               end else if (desc_full) begin
                  drop   = 1'b1;
                  spec_n = wr_commit;
               end else begin
                  push     = 1'b1;
                  spec_n   = spec_t;
                  commit_n = spec_t;
               end
            end else begin
               flen_n = len_t;
               spec_n = spec_t;
               if (stored) st_n = RECV;
            end
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (mem_we) mem[wr_spec[AW-1:0]] <= S_TDATA;
      if (push)   desc_mem[desc_tail] <= len_t;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state     <= IDLE;
         wr_spec   <= '0;
         wr_commit <= '0;
         frame_len <= '0;
         rd_ptr    <= '0;
         rd_word   <= '0;
         desc_head <= '0;
         desc_tail <= '0;
         desc_cnt  <= '0;
         RD_DATA   <= '0;
         RD_VALID  <= 1'b0;
         RD_LAST   <= 1'b0;
         PKT_NUM   <= '0;
         DROP_CNT  <= '0;
         OVERFLOW  <= 1'b0;
      end else begin
         state     <= st_n;
         wr_spec   <= spec_n;
         wr_commit <= commit_n;
         frame_len <= flen_n;
         OVERFLOW  <= drop;
         if (drop && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
         if (push) desc_tail <= idx_next(desc_tail);
         case ({push, pop})
            2'b10:   desc_cnt <= desc_cnt + CW'(1);
            2'b01:   desc_cnt <= desc_cnt - CW'(1);
            default: desc_cnt <= desc_cnt;
         endcase
         RD_VALID <= rd_fire;
         RD_LAST  <= pop;
         if (rd_fire) begin
            RD_DATA <= mem[rd_ptr[AW-1:0]];
            rd_ptr  <= rd_ptr + LEN_W'(1);
            rd_word <= pop ? '0 : rd_word + LEN_W'(1);
         end
         if (pop) begin
            desc_head <= idx_next(desc_head);
            PKT_NUM   <= PKT_NUM + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_capture.sv
// tb/tb_axi_stream_capture.sv - directed bench for axi_stream_capture across four parameter sets
module tb_axi_stream_capture;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        s_tvalid = 1'b0, s_tlast = 1'b0;
   logic [31:0] s_tdata = '0;
   logic [3:0]  s_tkeep = '0;
   logic [3:0]  rd_en = '0;
   wire  [3:0]  s_tready, rd_valid, rd_last, pkt_avail, overflow;
   wire  [31:0] rd_data [4];
   wire  [31:0] pkt_num [4];
   wire  [15:0] drop_cnt [4];
   wire  [10:0] pkt_len0;
   wire  [3:0]  pkt_len1;
   wire  [4:0]  pkt_len2, pkt_len3;
   int          vectors = 0, miscompares = 0;

   always #5 ACLK = ~ACLK;

   axi_stream_capture u0 (
      .ACLK(ACLK), .ARESET(ARESET), .S_TVALID(s_tvalid), .S_TDATA(s_tdata), .S_TKEEP(s_tkeep),
      .S_TLAST(s_tlast), .S_TREADY(s_tready[0]), .RD_EN(rd_en[0]), .RD_DATA(rd_data[0]),
      .RD_VALID(rd_valid[0]), .RD_LAST(rd_last[0]), .PKT_AVAIL(pkt_avail[0]), .PKT_LEN(pkt_len0),
      .PKT_NUM(pkt_num[0]), .DROP_CNT(drop_cnt[0]), .OVERFLOW(overflow[0]));

   axi_stream_capture #(.DEPTH(8), .PKT_DEPTH(16)) u1 (
      .ACLK(ACLK), .ARESET(ARESET), .S_TVALID(s_tvalid), .S_TDATA(s_tdata), .S_TKEEP(s_tkeep),
      .S_TLAST(s_tlast), .S_TREADY(s_tready[1]), .RD_EN(rd_en[1]), .RD_DATA(rd_data[1]),
      .RD_VALID(rd_valid[1]), .RD_LAST(rd_last[1]), .PKT_AVAIL(pkt_avail[1]), .PKT_LEN(pkt_len1),
      .PKT_NUM(pkt_num[1]), .DROP_CNT(drop_cnt[1]), .OVERFLOW(overflow[1]));

   axi_stream_capture #(.DEPTH(16), .PKT_DEPTH(2)) u2 (
      .ACLK(ACLK), .ARESET(ARESET), .S_TVALID(s_tvalid), .S_TDATA(s_tdata), .S_TKEEP(s_tkeep),
      .S_TLAST(s_tlast), .S_TREADY(s_tready[2]), .RD_EN(rd_en[2]), .RD_DATA(rd_data[2]),
      .RD_VALID(rd_valid[2]), .RD_LAST(rd_last[2]), .PKT_AVAIL(pkt_avail[2]), .PKT_LEN(pkt_len2),
      .PKT_NUM(pkt_num[2]), .DROP_CNT(drop_cnt[2]), .OVERFLOW(overflow[2]));

   axi_stream_capture #(.DEPTH(16), .PKT_DEPTH(16)) u3 (
      .ACLK(ACLK), .ARESET(ARESET), .S_TVALID(s_tvalid), .S_TDATA(s_tdata), .S_TKEEP(s_tkeep),
      .S_TLAST(s_tlast), .S_TREADY(s_tready[3]), .RD_EN(rd_en[3]), .RD_DATA(rd_data[3]),
      .RD_VALID(rd_valid[3]), .RD_LAST(rd_last[3]), .PKT_AVAIL(pkt_avail[3]), .PKT_LEN(pkt_len3),
      .PKT_NUM(pkt_num[3]), .DROP_CNT(drop_cnt[3]), .OVERFLOW(overflow[3]));

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
      tick();
      s_tvalid = 1'b0; s_tkeep = '0; s_tlast = 1'b0;
   endtask

   task automatic do_reset();
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({s_tready[i], rd_valid[i], rd_last[i], pkt_avail[i], overflow[i]} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags[%0d]: got %b want 00000", i,
                     {s_tready[i], rd_valid[i], rd_last[i], pkt_avail[i], overflow[i]});
         end
         vectors++;
         if ({rd_data[i], pkt_num[i], drop_cnt[i]} !== 80'b0) begin
            miscompares++;
            $display("FAIL reset_values[%0d]: got data=%h num=%0d drop=%0d want 0", i,
                     rd_data[i], pkt_num[i], drop_cnt[i]);
         end
      end
      vectors++;
      if ({pkt_len0, pkt_len1, pkt_len2, pkt_len3} !== 25'b0) begin
         miscompares++;
         $display("FAIL reset_pkt_len: got %0d %0d %0d %0d want 0", pkt_len0, pkt_len1, pkt_len2, pkt_len3);
      end
      ARESET = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      beat(32'd1, 4'hF, 1'b0);
      beat(32'd2, 4'hF, 1'b0);
      beat(32'd3, 4'hF, 1'b1);
      vectors++;
      if ({pkt_avail[0], pkt_len0} !== {1'b1, 11'd3}) begin
         miscompares++;
         $display("FAIL basic_avail_len: got avail=%b len=%0d want avail=1 len=3", pkt_avail[0], pkt_len0);
      end
      for (int i = 1; i <= 3; i++) begin
         rd_en[0] = 1'b1;
         tick();
         rd_en[0] = 1'b0;
         vectors++;
         if ({rd_valid[0], rd_last[0], rd_data[0]} !== {1'b1, (i == 3), 32'(i)}) begin
            miscompares++;
            $display("FAIL basic_read%0d: got v=%b l=%b d=%0d want v=1 l=%b d=%0d", i,
                     rd_valid[0], rd_last[0], rd_data[0], (i == 3), i);
         end
      end
      vectors++;
      if ({pkt_avail[0], pkt_num[0]} !== {1'b0, 32'd1}) begin
         miscompares++;
         $display("FAIL basic_pkt_num: got avail=%b num=%0d want avail=0 num=1", pkt_avail[0], pkt_num[0]);
      end
      rd_en[0] = 1'b1;
      tick();
      rd_en[0] = 1'b0;
      vectors++;
      if (rd_valid[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_rd_empty: got rd_valid=%b want 0", rd_valid[0]);
      end
   endtask

   task automatic test_null_beats();
      do_reset();
      beat(32'hA, 4'hF, 1'b0);
      beat(32'hB, 4'h0, 1'b0);
      beat(32'hC, 4'hF, 1'b0);
      beat(32'hD, 4'h0, 1'b1);
      vectors++;
      if ({pkt_avail[0], pkt_len0} !== {1'b1, 11'd2}) begin
         miscompares++;
         $display("FAIL null_len: got avail=%b len=%0d want avail=1 len=2", pkt_avail[0], pkt_len0);
      end
      for (int i = 0; i < 2; i++) begin
         rd_en[0] = 1'b1;
         tick();
         rd_en[0] = 1'b0;
         vectors++;
         if ({rd_valid[0], rd_last[0], rd_data[0]} !== {1'b1, (i == 1), (i == 1) ? 32'hC : 32'hA}) begin
            miscompares++;
            $display("FAIL null_read%0d: got v=%b l=%b d=%h", i, rd_valid[0], rd_last[0], rd_data[0]);
         end
      end
      beat(32'hE, 4'h0, 1'b0);
      beat(32'hF, 4'h0, 1'b1);
      tick();
      vectors++;
      if ({pkt_avail[0], drop_cnt[0], pkt_num[0]} !== {1'b0, 16'd0, 32'd1}) begin
         miscompares++;
         $display("FAIL null_only_frame: got avail=%b drop=%0d num=%0d want 0 0 1",
                  pkt_avail[0], drop_cnt[0], pkt_num[0]);
      end
   endtask

   task automatic test_buf_overflow();
      int ov = 0;
      do_reset();
      for (int i = 0; i < 6; i++) beat(32'h10 + 32'(i), 4'hF, i == 5);
      for (int i = 0; i < 4; i++) begin
         beat(32'h20 + 32'(i), 4'hF, i == 3);
         ov += int'(overflow[1]);
      end
      tick();
      ov += int'(overflow[1]);
      vectors++;
      if (ov !== 1) begin
         miscompares++;
         $display("FAIL ovf_pulses: got %0d want 1", ov);
      end
      vectors++;
      if ({drop_cnt[1], pkt_avail[1], pkt_len1} !== {16'd1, 1'b1, 4'd6}) begin
         miscompares++;
         $display("FAIL ovf_state: got drop=%0d avail=%b len=%0d want 1 1 6", drop_cnt[1], pkt_avail[1], pkt_len1);
      end
      for (int i = 0; i < 6; i++) begin
         rd_en[1] = 1'b1;
         tick();
         rd_en[1] = 1'b0;
         vectors++;
         if ({rd_valid[1], rd_last[1], rd_data[1]} !== {1'b1, (i == 5), 32'h10 + 32'(i)}) begin
            miscompares++;
            $display("FAIL ovf_read%0d: got v=%b l=%b d=%h", i, rd_valid[1], rd_last[1], rd_data[1]);
         end
      end
      beat(32'h30, 4'hF, 1'b0);
      beat(32'h31, 4'hF, 1'b1);
      vectors++;
      if ({pkt_avail[1], pkt_len1} !== {1'b1, 4'd2}) begin
         miscompares++;
         $display("FAIL ovf_refill_len: got avail=%b len=%0d want 1 2", pkt_avail[1], pkt_len1);
      end
      for (int i = 0; i < 2; i++) begin
         rd_en[1] = 1'b1;
         tick();
         rd_en[1] = 1'b0;
         vectors++;
         if ({rd_valid[1], rd_last[1], rd_data[1]} !== {1'b1, (i == 1), 32'h30 + 32'(i)}) begin
            miscompares++;
            $display("FAIL ovf_refill_read%0d: got v=%b l=%b d=%h", i, rd_valid[1], rd_last[1], rd_data[1]);
         end
      end
   endtask

   task automatic test_desc_full();
      do_reset();
      beat(32'h41, 4'hF, 1'b1);
      beat(32'h42, 4'hF, 1'b1);
      beat(32'h43, 4'hF, 1'b1);
      vectors++;
      if ({overflow[2], drop_cnt[2], pkt_avail[2], pkt_len2} !== {1'b1, 16'd1, 1'b1, 5'd1}) begin
         miscompares++;
         $display("FAIL desc_full_drop: got ovf=%b drop=%0d avail=%b len=%0d want 1 1 1 1",
                  overflow[2], drop_cnt[2], pkt_avail[2], pkt_len2);
      end
      for (int i = 0; i < 2; i++) begin
         rd_en[2] = 1'b1;
         tick();
         rd_en[2] = 1'b0;
         vectors++;
         if ({rd_valid[2], rd_last[2], rd_data[2]} !== {1'b1, 1'b1, 32'h41 + 32'(i)}) begin
            miscompares++;
            $display("FAIL desc_full_read%0d: got v=%b l=%b d=%h", i, rd_valid[2], rd_last[2], rd_data[2]);
         end
      end
      vectors++;
      if ({pkt_avail[2], pkt_num[2]} !== {1'b0, 32'd2}) begin
         miscompares++;
         $display("FAIL desc_full_after: got avail=%b num=%0d want 0 2", pkt_avail[2], pkt_num[2]);
      end
   endtask

   task automatic test_stream();
      logic [32:0] exp_q[$];
      bit          wr_done = 1'b0;
      int          cyc = 0;
      do_reset();
      fork
         begin
            for (int f = 0; f < 100; f++) begin
               int len = int'($urandom_range(1, 7));
               for (int w = 0; w < len; w++) begin
                  logic [31:0] d = $urandom;
                  exp_q.push_back({(w == len - 1), d});
                  beat(d, 4'hF, w == len - 1);
               end
               tick();
            end
            wr_done = 1'b1;
         end
         begin
            rd_en[3] = 1'b1;
            while (!(wr_done && exp_q.size() == 0) && cyc < 5000) begin
               tick();
               cyc++;
               if (rd_valid[3] === 1'b1) begin
                  logic [32:0] e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
                  vectors++;
                  if ({rd_last[3], rd_data[3]} !== e) begin
                     miscompares++;
                     $display("FAIL stream_word: got l=%b d=%h want l=%b d=%h",
                              rd_last[3], rd_data[3], e[32], e[31:0]);
                  end
               end
            end
            rd_en[3] = 1'b0;
         end
      join
      vectors++;
      if (cyc >= 5000) begin
         miscompares++;
         $display("FAIL stream_timeout: got %0d words left want 0", exp_q.size());
      end
      vectors++;
      if ({drop_cnt[3], pkt_num[3], pkt_avail[3]} !== {16'd0, 32'd100, 1'b0}) begin
         miscompares++;
         $display("FAIL stream_totals: got drop=%0d num=%0d avail=%b want 0 100 0",
                  drop_cnt[3], pkt_num[3], pkt_avail[3]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      beat(32'h50, 4'hF, 1'b1);
      beat(32'h60, 4'hF, 1'b1);
      beat(32'h61, 4'hF, 1'b0);
      rd_en[0] = 1'b1;
      beat(32'h62, 4'hF, 1'b0);
      rd_en[0] = 1'b0;
      vectors++;
      if ({rd_valid[0], rd_data[0], pkt_avail[0], pkt_num[0]} !== {1'b1, 32'h50, 1'b1, 32'd1}) begin
         miscompares++;
         $display("FAIL midreset_pre: got v=%b d=%h avail=%b num=%0d want 1 50 1 1",
                  rd_valid[0], rd_data[0], pkt_avail[0], pkt_num[0]);
      end
      ARESET = 1'b1;
      #1;
      vectors++;
      if ({s_tready[0], rd_valid[0], rd_last[0], pkt_avail[0], overflow[0], rd_data[0],
           pkt_len0, pkt_num[0], drop_cnt[0]} !== 96'b0) begin
         miscompares++;
         $display("FAIL midreset_outputs: got rdy=%b v=%b d=%h avail=%b len=%0d num=%0d drop=%0d want 0",
                  s_tready[0], rd_valid[0], rd_data[0], pkt_avail[0], pkt_len0, pkt_num[0], drop_cnt[0]);
      end
      tick();
      ARESET = 1'b0;
      beat(32'h70, 4'hF, 1'b1);
      vectors++;
      if ({pkt_avail[0], pkt_len0} !== {1'b1, 11'd1}) begin
         miscompares++;
         $display("FAIL midreset_new_len: got avail=%b len=%0d want 1 1", pkt_avail[0], pkt_len0);
      end
      rd_en[0] = 1'b1;
      tick();
      rd_en[0] = 1'b0;
      vectors++;
      if ({rd_valid[0], rd_last[0], rd_data[0], pkt_avail[0]} !== {1'b1, 1'b1, 32'h70, 1'b0}) begin
         miscompares++;
         $display("FAIL midreset_new_read: got v=%b l=%b d=%h avail=%b want 1 1 70 0",
                  rd_valid[0], rd_last[0], rd_data[0], pkt_avail[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_null_beats();
      test_buf_overflow();
      test_desc_full();
      test_stream();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by 1ms want finish");
      $fatal(1);
   end

endmodule

// File: doc/axi_stream_capture.md
AXI_STREAM_CAPTURE -- requirements
Module: axi_stream_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 32: S_TDATA/RD_DATA width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024: data buffer depth in DATA_W words, a power of 2, at least 4.
REQ-003 SHALL have parameter PKT_DEPTH, default 16: descriptor FIFO depth in packets, a power of 2.
REQ-004 SHALL derive LEN_W = clog2(DEPTH)+1 as the length field width.
REQ-005 SHALL have port ACLK, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port ARESET, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port S_TVALID, input, 1: stream beat valid.
REQ-008 SHALL have port S_TDATA, input, DATA_W: stream data.
REQ-009 SHALL have port S_TKEEP, input, DATA_W/8: byte keep; all-zero marks a null beat.
REQ-010 SHALL have port S_TLAST, input, 1: last beat of a frame.
REQ-011 SHALL have port S_TREADY, output, 1: beat accept.
REQ-012 SHALL have port RD_EN, input, 1: pop one word of the head packet.
REQ-013 SHALL have ports RD_DATA (output, DATA_W) and RD_VALID (output, 1): read word and its valid flag.
REQ-014 SHALL have port RD_LAST, output, 1: RD_DATA is the final word of the packet.
REQ-015 SHALL have ports PKT_AVAIL (output, 1) and PKT_LEN (output, LEN_W): at least one complete packet buffered; head packet length in words.
REQ-016 SHALL have ports PKT_NUM (output, 32) and DROP_CNT (output, 16): count of packets fully read; count of dropped frames.
REQ-017 SHALL have port OVERFLOW, output, 1: one-cycle pulse when a frame is dropped.

Function
REQ-018 SHALL drive S_TREADY high at all times outside reset; the block never back-pressures and drops frames instead.
REQ-019 SHALL accept a beat on a rising edge with S_TVALID=1, and SHALL ignore S_TDATA/S_TKEEP/S_TLAST when S_TVALID=0.
REQ-020 SHALL store a beat with any nonzero S_TKEEP as one whole word; SHALL not store a null beat, but a null beat's S_TLAST SHALL still end the frame.
REQ-021 SHALL run a write state machine with states IDLE, RECV and DROP; reset state SHALL be IDLE.
REQ-022 IDLE→RECV on the first stored beat without S_TLAST; RECV→IDLE on S_TLAST; on a single-beat frame (S_TLAST on first beat) SHALL commit directly and remain in IDLE.
REQ-023 SHALL write each word at a speculative pointer; on S_TLAST SHALL commit that pointer and push the frame word count into the descriptor FIFO in the same cycle.
REQ-024 SHALL treat the buffer as full when speculative pointer minus read pointer equals DEPTH, with pointers LEN_W bits wide and modulo wrap.
REQ-025 A stored beat arriving while full SHALL restore the speculative pointer to the committed value, increment DROP_CNT, pulse OVERFLOW and enter DROP; if that beat has S_TLAST, SHALL return to IDLE.
REQ-026 DROP SHALL discard beats until S_TLAST, then go to IDLE; only one drop SHALL be counted per frame.
REQ-027 S_TLAST with the descriptor FIFO full SHALL discard the frame, with the same counting and pulse as REQ-025.
REQ-028 A zero-word frame (only null beats) SHALL be discarded silently: no descriptor, no drop count.
REQ-029 DROP_CNT SHALL saturate at 16'hFFFF; PKT_NUM SHALL wrap modulo 2^32.
REQ-030 PKT_AVAIL SHALL be high when the descriptor FIFO is non-empty; PKT_LEN SHALL show the head length, or 0 when empty.
REQ-031 RD_EN with PKT_AVAIL=1 SHALL produce the next word on RD_DATA with RD_VALID=1 exactly one cycle later; RD_EN with PKT_AVAIL=0 SHALL be ignored.
REQ-032 Buffer space SHALL be freed per word read, and the freed space SHALL be usable by the write side on the next cycle.
REQ-033 On reading the head packet's last word, RD_LAST SHALL assert with it, the descriptor SHALL pop, and PKT_NUM SHALL increment in the same cycle as RD_VALID.
REQ-034 Simultaneous descriptor push and pop SHALL leave the descriptor count unchanged; push to an empty FIFO SHALL raise PKT_AVAIL the next cycle.
REQ-035 Words of an uncommitted frame SHALL never be readable.

Reset
REQ-036 While ARESET=1, all pointers, counters and the descriptor FIFO SHALL clear; the state SHALL be IDLE; S_TREADY, RD_VALID, RD_LAST, PKT_AVAIL, OVERFLOW SHALL be 0; RD_DATA, PKT_LEN, PKT_NUM and DROP_CNT SHALL be 0.
REQ-037 Reset mid-frame or mid-read SHALL discard all buffered and partial data; the first beat after release SHALL start a new frame.

Verification
REQ-038 Bench SHALL cover: 3-beat frame, data 1,2,3, full keep → PKT_AVAIL=1, PKT_LEN=3; 3 RD_EN pulses return 1,2,3 with RD_LAST on 3; then PKT_NUM=1.
REQ-039 Bench SHALL cover: frame of 4 beats with keep 0xF,0x0,0xF,0x0+TLAST → PKT_LEN=2; a frame of only null beats → PKT_AVAIL stays 0 and DROP_CNT stays 0.
REQ-040 Bench SHALL cover: DEPTH=8, frames of 6 then 4 words, no reads → second frame dropped, DROP_CNT=1, one OVERFLOW pulse, PKT_LEN=6.
REQ-041 Bench SHALL cover: PKT_DEPTH=2, three 1-word frames, no reads → third frame dropped, DROP_CNT=1.
REQ-042 Bench SHALL cover: continuous reading while writing 100 frames of random length 1-7 words, DEPTH=16 → every frame read back intact, wrapping across the pointer boundary.
REQ-043 Bench SHALL cover: ARESET asserted after 2 beats of a 5-beat frame → all outputs 0; a post-reset 1-beat frame is read back alone.
